// File: rtl/hex_display_counter_if.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_counter_if
// Brief   : Control, count and segment bundle for hex_display_counter.
// Revision: 1.0
// ============================================================================
interface hex_display_counter_if #(
  parameter int DIGITS = 4
);
  logic                  enable;
  logic                  up;
  logic                  bcd_mode;
  logic                  load;
  logic [4*DIGITS-1:0]   load_value;
  logic                  blank_lz;
  logic [4*DIGITS-1:0]   count;
  logic                  wrap;
  logic [7*DIGITS-1:0]   hex;

  modport master (
    output enable, up, bcd_mode, load, load_value, blank_lz,
    input  count, wrap, hex
  );

  modport slave (
    input  enable, up, bcd_mode, load, load_value, blank_lz,
    output count, wrap, hex
  );
endinterface
`default_nettype wire

// File: rtl/hex_display_counter.sv
`default_nettype none
// ============================================================================
// Module  : hex_display_counter
// Brief   : Prescaled hex/BCD up/down digit counter with registered,
//           active-low seven-segment decode and leading-zero blanking.
// Revision: 1.0
// ============================================================================
module hex_display_counter #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 1
) (
  input  wire logic             clock,
  input  wire logic             reset,
  hex_display_counter_if.slave  bus
);
  localparam int              c_pw   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0] c_pmax = c_pw'(PRESCALE - 1);
  localparam logic [6:0]      c_zero = 7'b0000001;

  logic [4*DIGITS-1:0] r_count;
  logic                r_wrap;
  logic [c_pw-1:0]     r_presc;
  logic [7*DIGITS-1:0] r_hex;

  logic [4*DIGITS-1:0] w_next;
  logic                w_carry;
  logic [3:0]          w_d;
  logic [4*DIGITS-1:0] w_load_val;
  logic [7*DIGITS-1:0] w_hex;
  logic                w_zero_above;
  logic                w_tick;

  assign w_tick    = bus.enable && (r_presc == c_pmax);
  assign bus.count = r_count;
  assign bus.wrap  = r_wrap;
  assign bus.hex   = r_hex;

  function automatic logic [6:0] seg7(input logic [3:0] d, input logic bcd);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0001100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    if (bcd && (d > 4'd9)) s = 7'b1111110;
    return s;
  endfunction

  // Per-nibble ripple step; w_carry leaving the top digit is the wrap condition.
  always_comb begin
    w_next  = r_count;
    w_carry = 1'b1;
    w_d     = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      w_d = r_count[4*i +: 4];
      if (w_carry) begin
        if (bus.up) begin
          if (bus.bcd_mode ? (w_d >= 4'd9) : (w_d == 4'hF)) begin
            w_next[4*i +: 4] = 4'd0;
          end else begin
            w_next[4*i +: 4] = w_d + 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (w_d == 4'd0) begin
            w_next[4*i +: 4] = bus.bcd_mode ? 4'd9 : 4'hF;
          end else begin
            w_next[4*i +: 4] = (bus.bcd_mode && (w_d > 4'd9)) ? 4'd8 : (w_d - 4'd1);
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    w_load_val = bus.load_value;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_mode && (bus.load_value[4*i +: 4] > 4'd9)) w_load_val[4*i +: 4] = 4'd9;
    end
  end

  // Blanking walks down from the top digit while every digit seen so far is zero.
  always_comb begin
    w_hex        = '0;
    w_zero_above = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_above = w_zero_above && (r_count[4*i +: 4] == 4'd0);
      if (bus.blank_lz && w_zero_above && (i != 0)) w_hex[7*i +: 7] = 7'b1111111;
      else w_hex[7*i +: 7] = seg7(r_count[4*i +: 4], bus.bcd_mode);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_presc <= '0;
      r_hex   <= {DIGITS{c_zero}};
    end else begin
      r_hex <= w_hex;
      if (bus.load) begin
        r_count <= w_load_val;
        r_wrap  <= 1'b0;
        r_presc <= '0;
      end else if (w_tick) begin
        r_count <= w_next;
        r_wrap  <= w_carry;
        r_presc <= '0;
      end else begin
        r_wrap <= 1'b0;
        if (bus.enable) r_presc <= r_presc + c_pw'(1);
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_hex_display_counter.sv
`default_nettype none
// ============================================================================
// Module  : tb_hex_display_counter
// Brief   : Vector-table and scoreboard bench for hex_display_counter.
// Revision: 1.0
// ============================================================================
module tb_hex_display_counter;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S8 = 7'b0000000;
  localparam logic [6:0] S9 = 7'b0001100, SA = 7'b0001000, SE = 7'b0110000;
  localparam logic [6:0] SF = 7'b0111000, SB = 7'b1111111, SD = 7'b1111110;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  hex_display_counter_if #(.DIGITS(4)) ifa ();
  hex_display_counter_if #(.DIGITS(4)) ifb ();

  hex_display_counter #(.DIGITS(4), .PRESCALE(1)) dut_a (.clock(clk), .reset(rst_a), .bus(ifa));
  hex_display_counter #(.DIGITS(4), .PRESCALE(3)) dut_b (.clock(clk), .reset(rst_b), .bus(ifb));

  typedef struct {
    logic        rst, en, up, bcd, ld, blz;
    logic [15:0] lv;
    logic [15:0] ec;
    logic        ew;
    logic        chk;
    logic [27:0] eh;
  } vec_t;

  typedef struct {
    logic [15:0] c;
    logic        w;
    logic        chk;
    logic [27:0] h;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t row(input logic rst, en, up, bcd, ld, blz, input logic [15:0] lv,
                               input logic [15:0] ec, input logic ew, input logic chk,
                               input logic [27:0] eh);
    vec_t v;
    v.rst = rst; v.en = en; v.up = up; v.bcd = bcd; v.ld = ld; v.blz = blz;
    v.lv = lv; v.ec = ec; v.ew = ew; v.chk = chk; v.eh = eh;
    return v;
  endfunction

  task automatic compare(input string tag, input logic [15:0] c, input logic w, input logic [27:0] h);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty", tag);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (c !== e.c) begin
      errors++;
      $display("FAIL %s count got %h want %h", tag, c, e.c);
    end
    checks++;
    if (w !== e.w) begin
      errors++;
      $display("FAIL %s wrap got %b want %b", tag, w, e.w);
    end
    if (e.chk) begin
      checks++;
      if (h !== e.h) begin
        errors++;
        $display("FAIL %s hex got %b want %b", tag, h, e.h);
      end
    end
  endtask

  task automatic step(input logic which, input vec_t v, input string tag);
    exp_t e;
    @(negedge clk);
    if (which == 1'b0) begin
      rst_a = v.rst; ifa.enable = v.en; ifa.up = v.up; ifa.bcd_mode = v.bcd;
      ifa.load = v.ld; ifa.blank_lz = v.blz; ifa.load_value = v.lv;
    end else begin
      rst_b = v.rst; ifb.enable = v.en; ifb.up = v.up; ifb.bcd_mode = v.bcd;
      ifb.load = v.ld; ifb.blank_lz = v.blz; ifb.load_value = v.lv;
    end
    e.c = v.ec; e.w = v.ew; e.chk = v.chk; e.h = v.eh;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (which == 1'b0) compare(tag, ifa.count, ifa.wrap, ifa.hex);
    else               compare(tag, ifb.count, ifb.wrap, ifb.hex);
  endtask

  initial begin
    rst_a = 1'b1; rst_b = 1'b1;
    ifa.enable = 1'b0; ifa.up = 1'b1; ifa.bcd_mode = 1'b0; ifa.load = 1'b0;
    ifa.blank_lz = 1'b0; ifa.load_value = 16'h0;
    ifb.enable = 1'b0; ifb.up = 1'b1; ifb.bcd_mode = 1'b0; ifb.load = 1'b0;
    ifb.blank_lz = 1'b0; ifb.load_value = 16'h0;

    //              rst   en    up    bcd   ld    blz   lv        count    wrap  chk   hex
    vecs.push_back(row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, {SF,SF,SF,SE}));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, {SF,SF,SF,SF}));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0001, 1'b0, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0001, 16'h0001, 1'b0, 1'b1, {S0,S0,S0,S1}));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b1, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1, {S9,S9,S9,S9}));
    vecs.push_back(row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9998, 1'b0, 1'b1, {S9,S9,S9,S8}));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 16'hABCD, 16'h9999, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b1, {S9,S9,S9,S9}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 16'h00A0, 16'h00A0, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 16'h00A0, 1'b0, 1'b1, {SB,SB,SA,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h00A0, 1'b0, 1'b1, {SB,SB,SD,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, {SB,SB,SD,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b1, {SB,SB,SB,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h000C, 16'h000C, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, {S0,S0,S0,SD}));
    vecs.push_back(row(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0008, 1'b0, 1'b1, {S0,S0,S0,S8}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'h9998, 16'h9998, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h9999, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, {S9,S9,S9,S9}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 28'h0));
    vecs.push_back(row(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b1, 1'b1, {S0,S0,S0,S0}));
    vecs.push_back(row(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'hFFFF, 1'b0, 1'b1, {SF,SF,SF,SF}));

    foreach (vecs[i]) step(1'b0, vecs[i], $sformatf("a_row%0d", i));

    // Prescale-by-3 unit: reset, load, then enabled/disabled stretches.
    step(1'b1, row(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b1, {S0,S0,S0,S0}), "b_reset");
    step(1'b1, row(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0000, 1'b0, 1'b0, 28'h0), "b_load");
    for (int k = 1; k <= 9; k++)
      step(1'b1, row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'(k / 3), 1'b0, 1'b0, 28'h0),
           $sformatf("b_run%0d", k));
    for (int k = 0; k < 5; k++)
      step(1'b1, row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0003, 1'b0, 1'b0, 28'h0),
           $sformatf("b_hold%0d", k));
    step(1'b1, row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0003, 1'b0, 1'b0, 28'h0), "b_resume0");
    for (int k = 0; k < 3; k++)
      step(1'b1, row(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0003, 1'b0, 1'b0, 28'h0),
           $sformatf("b_pause%0d", k));
    step(1'b1, row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0003, 1'b0, 1'b0, 28'h0), "b_resume1");
    step(1'b1, row(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0004, 1'b0, 1'b0, 28'h0), "b_resume2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/hex_display_counter.md
Name: hex_display_counter

Overview:
- Parametrised multi-digit counter with an integrated seven-segment display driver for the board HEX displays.
- Counts up or down at a prescaled rate. Supports hexadecimal or BCD (decimal) mode, parallel load, a wrap pulse and leading-zero blanking.
- Sits between the board clock and the HEX outputs and replaces the fixed 16-bit counter plus per-digit decoder arrangement.

Parameters:
- DIGITS, 4: number of 4-bit digits and seven-segment fields (1..8).
- PRESCALE, 1: clock cycles per count step (1..2^24). A value of 1 means the count steps on every enabled cycle.

Ports:
- clock  in  1: system clock, rising edge.
- reset  in  1: synchronous, active-high reset.
- enable  in  1: allows the prescaler and counter to advance.
- up  in  1: 1 = increment, 0 = decrement.
- bcd_mode  in  1: 0 = hex (digits 0..F), 1 = BCD (digits 0..9).
- load  in  1: parallel load strobe.
- load_value  in  4*DIGITS: value for load; nibble i is digit i, and digit 0 is least significant.
- blank_lz  in  1: blank leading zero digits.
- count  out  4*DIGITS: current count, registered.
- wrap  out  1: one-cycle pulse on a wrap-around step.
- hex  out  7*DIGITS: segment bus, active-low; field i = hex[7i+6:7i] drives digit i, with bit 7i+6 = segment a and bit 7i = segment g (literal order abcdefg).

Behaviour:
Reset:
- When reset is high at a clock edge: count = 0, wrap = 0, prescaler = 0, and every hex field = 0000001 (shows "0", no blanking).
- Reset overrides load and enable.

Prescaler:
- The internal counter runs 0..PRESCALE-1 while enable = 1 and holds while enable = 0.
- tick = enable && (prescaler == PRESCALE-1). The prescaler returns to 0 on tick.

Priority per cycle: reset > load > tick > hold.
- Load:
  - Takes effect on the next edge regardless of enable.
  - Sets prescaler = 0 and wrap = 0.
  - In BCD mode each loaded nibble > 9 is stored as 9. In hex mode nibbles are stored unchanged.
- Tick with up = 1: ripple increment from digit 0.
  - A digit at its maximum (F in hex; 9 in BCD, or any nibble > 9 in BCD) becomes 0 and carries to the next digit.
- Tick with up = 0: ripple decrement.
  - A digit at 0 becomes its maximum (F or 9) and borrows from the next digit.
  - In BCD mode a nibble > 9 decrements as if it were 9, giving 8.
- Wrap:
  - A carry out of digit DIGITS-1 (up, all digits at max) or a borrow out of it (down, all digits zero) sets wrap = 1 for exactly that cycle.
  - Result after an up wrap: all zeros. Result after a down wrap: all F in hex, all 9 in BCD.
  - wrap = 0 on every other cycle.
- bcd_mode may change at any time. It affects only subsequent steps and the decode; stored digits are not rewritten.

Display:
- hex is registered from count, so its latency is 1 cycle after count updates (2 edges after the causing input).
- Decode per digit (abcdefg, active-low):
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0001100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
- In BCD mode, nibbles > 9 display as dash 1111110.
- Blanking: when blank_lz = 1, each digit from DIGITS-1 downward that is 0, with all higher digits also 0, displays 1111111. Digit 0 is never blanked.

Width rules:
- All arithmetic is per-nibble. There is no binary adder across the full width in BCD mode.
- The prescaler width is clog2(PRESCALE), with a minimum of 1 bit.

Test Plan:
1. Hex count up: DIGITS = 4, PRESCALE = 1, enable = 1, up = 1, bcd_mode = 0, load FFFE.
   - Required: count FFFF then 0000. wrap = 1 in the cycle count becomes 0000, and 0 otherwise.
   - Required: hex = all fields 0000001 one cycle after count = 0000.
2. BCD count down: bcd_mode = 1, load 0001, up = 0, enable = 1.
   - Required: count 0000 then 9999 with a wrap pulse, then 9998.
   - Required: hex field 0 shows 0000000 (8), fields 1..3 show 0001100 (9).
3. Prescaler: PRESCALE = 3, load 0000, enable = 1 for 9 cycles, then enable = 0 for 5 cycles.
   - Required: count reaches 0003, advancing every third cycle, and stays 0003 while disabled.
   - Required: the prescaler resumes from its held value when enable returns.
4. Load conflicts: load ABCD with bcd_mode = 1 and tick in the same cycle.
   - Required: count = 9999, no increment that cycle, wrap = 0.
   - Then reset = 1 together with load = 1: count = 0000 and hex = 0000001 in every field.
5. Blanking and dash: bcd_mode = 0, load 00A0, blank_lz = 1.
   - Required: fields 3 and 2 = 1111111, field 1 = 0001000, field 0 = 0000001.
   - Then switch bcd_mode = 1 with no step: field 1 = 1111110.
   - Then load 0000: fields 3..1 blank, field 0 = 0000001.
6. BCD decrement of an out-of-range digit: hex mode load 000C, switch to bcd_mode = 1, step up = 0.
   - Required: count 000B is not produced. count = 0008 and wrap = 0.
